// File: rtl/alu_mul.sv
// Iterative radix-2 RV32M multiplier (MUL/MULH/MULHSU/MULHU), one multiplier bit per cycle.
// Optional ALU_MUL_EARLY_TERM_EN: leave BUSY once the remaining multiplier bits are all zero.
module alu_mul (
    input  logic        clk,
    input  logic        nReset,
    input  logic        alu_mul_stb_i,
    input  logic [4:0]  alu_mul_funct_i,
    input  logic [31:0] alu_mul_op1_i,
    input  logic [31:0] alu_mul_op2_i,
    output logic [31:0] alu_mul_res_o,
    output logic        alu_mul_done_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 2 * XLEN;
    localparam int unsigned CNT_W = 5;

    localparam logic [4:0] FUNCT_MUL    = 5'd14;
    localparam logic [4:0] FUNCT_MULH   = 5'd15;
    localparam logic [4:0] FUNCT_MULHSU = 5'd16;
    localparam logic [4:0] FUNCT_MULHU  = 5'd17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PLEN-1:0]   acc_q, acc_d;
    logic [PLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              low_q, low_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              done_q, done_d;

    logic              supported_c;
    logic              sign1_c, sign2_c;
    logic [XLEN-1:0]   mag1_c, mag2_c;
    logic [PLEN-1:0]   acc_add_c;
    logic [XLEN-1:0]   mplr_shift_c;
    logic              last_iter_c;
    logic [PLEN-1:0]   prod_c;

    // Operand decode: signed operands become magnitudes, unsigned ones contribute sign 0.
    always_comb begin
        supported_c = (alu_mul_funct_i == FUNCT_MUL)    || (alu_mul_funct_i == FUNCT_MULH) ||
                      (alu_mul_funct_i == FUNCT_MULHSU) || (alu_mul_funct_i == FUNCT_MULHU);
        sign1_c     = ((alu_mul_funct_i == FUNCT_MULH) || (alu_mul_funct_i == FUNCT_MULHSU))
                      && alu_mul_op1_i[XLEN-1];
        sign2_c     = (alu_mul_funct_i == FUNCT_MULH) && alu_mul_op2_i[XLEN-1];
        mag1_c      = sign1_c ? XLEN'(~alu_mul_op1_i + XLEN'(1)) : alu_mul_op1_i;
        mag2_c      = sign2_c ? XLEN'(~alu_mul_op2_i + XLEN'(1)) : alu_mul_op2_i;
    end

    // Shift-add step and final sign fix-up.
    always_comb begin
        acc_add_c    = mplr_q[0] ? PLEN'(acc_q + mcand_q) : acc_q;
        mplr_shift_c = mplr_q >> 1;
`ifdef ALU_MUL_EARLY_TERM_EN
        last_iter_c  = (cnt_q == CNT_W'(XLEN - 1)) || (mplr_shift_c == '0);
`else
        last_iter_c  = (cnt_q == CNT_W'(XLEN - 1));
`endif
        prod_c       = neg_q ? PLEN'(~acc_q + PLEN'(1)) : acc_q;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (alu_mul_stb_i) begin
                    state_d = supported_c ? BUSY : FIX;
                end
            end
            BUSY: begin
                if (last_iter_c) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        low_d   = low_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (alu_mul_stb_i) begin
                    acc_d   = '0;
                    mcand_d = {{XLEN{1'b0}}, mag1_c};
                    mplr_d  = mag2_c;
                    cnt_d   = '0;
                    neg_d   = sign1_c ^ sign2_c;
                    low_d   = (alu_mul_funct_i == FUNCT_MUL);
                end
            end
            BUSY: begin
                acc_d   = acc_add_c;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_shift_c;
                cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
            end
            FIX: begin
                res_d  = low_q ? prod_c[XLEN-1:0] : prod_c[PLEN-1:XLEN];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            low_q   <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            low_q   <= low_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign alu_mul_res_o  = res_q;
    assign alu_mul_done_o = done_q;

endmodule

// File: tb/tb_alu_mul.sv
// Scoreboard bench for alu_mul: stimulus pushes expected result and completion cycle, monitor pops on done.
module tb_alu_mul;

    logic        clk = 1'b0;
    logic        nReset;
    logic        stb;
    logic [4:0]  funct;
    logic [31:0] op1, op2;
    logic [31:0] res;
    logic        done;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_res = '0;

    alu_mul dut (
        .clk            (clk),
        .nReset         (nReset),
        .alu_mul_stb_i  (stb),
        .alu_mul_funct_i(funct),
        .alu_mul_op1_i  (op1),
        .alu_mul_op2_i  (op2),
        .alu_mul_res_o  (res),
        .alu_mul_done_o (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int lat(input logic [4:0] f, input logic [31:0] b);
        logic supported;
        supported = (f >= 5'd14) && (f <= 5'd17);
        if (!supported) return 1;
`ifdef ALU_MUL_EARLY_TERM_EN
        begin
            logic [31:0] mag;
            int          hb;
            mag = (f == 5'd15 && b[31]) ? (~b + 32'd1) : b;
            if (mag == 32'd0) return 2;
            hb = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
            return hb + 2;
        end
`else
        return 33;
`endif
    endfunction

    // Drive a strobe now; edge N is the next rising edge.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        exp_t e;
        stb   = 1'b1;
        funct = f;
        op1   = a;
        op2   = b;
        e.res = exp;
        e.cyc = cyc + 1 + lat(f, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        stb = 1'b0;
        op1 = ~a;
        op2 = ~b;
        funct = 5'd14;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    // Monitor: compare result and completion cycle on done, result hold otherwise.
    always @(negedge clk) begin
        if (!nReset) begin
            last_res = '0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done with res %h expected no done", res);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", res, e.res);
                    chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk("res_hold", res, last_res);
            end
            last_res = res;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        stb    = 1'b0;
        funct  = '0;
        op1    = '0;
        op2    = '0;
        repeat (3) @(negedge clk);
        chk("reset_res", res, 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        nReset = 1'b1;
        repeat (2) @(negedge clk);

        issue(5'd14, 32'hFFFFF8E1, 32'd10, 32'hFFFFB8CA);
        wait_done();
        // Back-to-back: each issue below strobes in the cycle done is high.
        issue(5'd15, 32'hFFFFFED7, 32'd16, 32'hFFFFFFFF);
        wait_done();
        issue(5'd16, 32'hFFFFF466, 32'h00000BFE, 32'hFFFFFFFF);
        wait_done();
        issue(5'd17, 32'hFFFFFED7, 32'h00003FB8, 32'h00003FB7);
        wait_done();
        issue(5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_done();
        issue(5'd15, 32'h80000000, 32'h80000000, 32'h40000000);
        wait_done();
        issue(5'd14, 32'd5, 32'd0, 32'd0);
        wait_done();

        // Strobe while busy must be ignored.
        @(negedge clk);
        issue(5'd17, 32'hFFFFFED7, 32'h00003FB8, 32'h00003FB7);
        repeat (4) @(negedge clk);
        stb   = 1'b1;
        funct = 5'd14;
        op1   = 32'd5;
        op2   = 32'd5;
        @(negedge clk);
        stb = 1'b0;
        wait_done();

        // Reset mid-operation aborts without done.
        @(negedge clk);
        issue(5'd14, 32'h00012345, 32'h00F00000, 32'h0);
        repeat (10) @(negedge clk);
        nReset = 1'b0;
        sb.delete();
        #2;
        chk("abort_res", res, 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        issue(5'd14, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        wait_done();

        @(negedge clk);
        issue(5'd3, 32'h00001234, 32'h00005678, 32'h0);
        wait_done();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
